stage_sequencer: RTL
====================

# stage_sequencer

Generates the wash-program stage number and the per-stage countdown that the cycle controller consumes. The cycle controller reads `stage_bus` and `timer_done`, decides when a stage is complete, and answers with `next` (advance) and `timer_select` (duration class). This block holds the current stage, times it, and steps through stages 0..12, wrapping to idle after the last stage.

## Interface
Parameters:
- `SHORT_TICKS`, default 4: clock cycles for a short-duration stage; must be ≥1.
- `LONG_TICKS`, default 10: clock cycles for a long-duration stage; must be ≥1.
- `TIMER_W`, default 16: counter width; must hold `max(SHORT_TICKS, LONG_TICKS) - 1`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `next` in 1: advance request from the cycle controller; level sampled each cycle.
- `timer_select` in 1: 0 selects short, 1 selects long; sampled only in LOAD.
- `abort` in 1: synchronous return to idle; highest priority.
- `pause` in 1: holds the countdown. Present only with `STAGE_PAUSE_EN`.
- `stage_bus` out 4: current stage, 0 = idle/wait-for-start, 1..12 = program stages.
- `timer_done` out 1: one-cycle pulse at countdown expiry.
- `cycle_done` out 1: one-cycle pulse when stage 12 advances to 0.
- `busy` out 1: high in LOAD and COUNT.

## Operation
- States: IDLE, LOAD, COUNT, EXPIRED.
- Reset: state IDLE; counter 0; `stage_bus`=0; `timer_done`=0; `cycle_done`=0; `busy`=0.
- IDLE: `stage_bus`=0. `next`=1 sets stage 1 and moves to LOAD.
- LOAD: lasts one cycle. Loads the counter with `(timer_select ? LONG_TICKS : SHORT_TICKS) - 1`, then moves to COUNT. `next` is ignored in LOAD.
- COUNT: the counter decrements each cycle.
  - When the counter is 0: pulse `timer_done` and move to EXPIRED.
  - `next`=1 in COUNT: early advance. The timer is discarded and no `timer_done` pulse occurs.
- EXPIRED: the counter is held. `next`=1 advances the stage.
- Advance rule, from COUNT or EXPIRED:
  - Stage < 12: stage+1, then LOAD.
  - Stage = 12: stage 0, IDLE, and `cycle_done` pulses.
- Simultaneous events:
  - `next` together with counter = 0 in COUNT: `next` wins and `timer_done` is suppressed.
  - `abort` overrides everything: the next state is IDLE with stage 0, `timer_done` and `cycle_done` are not asserted, and the counter is cleared.
- Stage arithmetic is 4-bit. Values 13..15 are unreachable; if they occur (for example through an SEU), the next cycle forces IDLE with stage 0.
- All outputs are registered.

## Timing
- `next` sampled high at edge E: the new `stage_bus` is visible after E (one-cycle latency).
- Stage changes at edge E, duration N:
  - Counter loaded at E+1.
  - Counter reaches 0 at E+N.
  - `timer_done` is high from E+N+1 to E+N+2.
- `cycle_done` and `timer_done` are each high for exactly one cycle and never together.
- `abort` sampled at edge E: `stage_bus`=0 after E.
- `rst_n` asserted mid-count: outputs clear immediately, without waiting for a clock edge.

## Configuration
- `STAGE_PAUSE_EN` defined:
  - The `pause` port exists.
  - `pause`=1 in COUNT holds the counter and blocks `timer_done`.
  - `next` and `abort` still act during pause.
  - `pause` has no effect in other states.
- Not defined: `pause` is absent and the countdown is unconditional.

## Structure
- Shared package `washer_pkg`:
  - Stage constants `STG_IDLE`=4'd0 and `STG_LAST`=4'd12.
  - Sequencer state encoding.
  - `STAGE_W`=4.
- Sub-module `stage_down_counter`:
  - Parameterised `TIMER_W`.
  - Inputs: `load`, `load_val`, `en`, `clr`.
  - Outputs: `zero`, and the count for debug.

## Test plan
- Reset, then `next` pulse, `timer_select`=0 → `stage_bus`=1 next cycle; `timer_done` pulses 5 cycles after the stage change (N=4); `busy` drops.
- `timer_select`=1 in LOAD, then changed to 0 during COUNT → `timer_done` 11 cycles after the stage change (N=10).
- `next` asserted in COUNT on the exact cycle the counter hits 0 → stage+1, no `timer_done` pulse.
- Walk stages 1..12 with `next` after each `timer_done` → stage 12 `next` gives `stage_bus`=0 and a single `cycle_done` pulse.
- `abort` mid-COUNT at stage 7 → `stage_bus`=0 next cycle, IDLE, no pulses. `rst_n` low mid-count → all outputs 0 asynchronously.
- With `STAGE_PAUSE_EN`: `pause` high for 3 cycles mid-count, N=4 → `timer_done` delayed by exactly 3 cycles.

Source files
------------

// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - shared stage constants and sequencer state encoding
package washer_pkg;

  localparam int STAGE_W = 4;

  localparam logic [STAGE_W-1:0] STG_IDLE  = 4'd0;
  localparam logic [STAGE_W-1:0] STG_FIRST = 4'd1;
  localparam logic [STAGE_W-1:0] STG_LAST  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COUNT   = 2'd2,
    S_EXPIRED = 2'd3
  } seq_state_t;

  function automatic logic stage_valid(input logic [STAGE_W-1:0] s);
    return s <= STG_LAST;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - cycle controller <-> stage sequencer bus
// Optional pause signal present only when STAGE_PAUSE_EN is defined.
interface stage_sequencer_if #(parameter int TIMER_W = 16);
  import washer_pkg::*;

  logic               next;
  logic               timer_select;
  logic               abort;
`ifdef STAGE_PAUSE_EN
  logic               pause;
`endif
  logic [STAGE_W-1:0] stage_bus;
  logic               timer_done;
  logic               cycle_done;
  logic               busy;
  logic [TIMER_W-1:0] count;

  modport master (
`ifdef STAGE_PAUSE_EN
    output pause,
`endif
    output next, timer_select, abort,
    input  stage_bus, timer_done, cycle_done, busy, count
  );

  modport slave (
`ifdef STAGE_PAUSE_EN
    input  pause,
`endif
    input  next, timer_select, abort,
    output stage_bus, timer_done, cycle_done, busy, count
  );

endinterface

// File: rtl/stage_down_counter.sv
// rtl/stage_down_counter.sv - loadable down counter that stops at zero
module stage_down_counter #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  input  logic               clr,
  output logic               zero,
  output logic [TIMER_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - wash-program stage stepper with per-stage countdown
// STAGE_PAUSE_EN adds a pause input that freezes the countdown.
module stage_sequencer
  import washer_pkg::*;
#(
  parameter int SHORT_TICKS = 4,
  parameter int LONG_TICKS  = 10,
  parameter int TIMER_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  stage_sequencer_if.slave bus
);

  localparam logic [TIMER_W-1:0] SHORT_LOAD = TIMER_W'(SHORT_TICKS - 1);
  localparam logic [TIMER_W-1:0] LONG_LOAD  = TIMER_W'(LONG_TICKS - 1);

  seq_state_t         state;
  logic [STAGE_W-1:0] stage;
  logic               timer_done_q;
  logic               cycle_done_q;
  logic               busy_q;
  logic               paused;
  logic               bad_stage;
  logic               cnt_zero;
  logic               cnt_load;
  logic               cnt_en;
  logic               cnt_clr;
  logic [TIMER_W-1:0] cnt;
  logic [TIMER_W-1:0] load_val;

`ifdef STAGE_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  assign bad_stage = !stage_valid(stage);
  assign load_val  = bus.timer_select ? LONG_LOAD : SHORT_LOAD;
  assign cnt_load  = (state == S_LOAD);
  assign cnt_en    = (state == S_COUNT) && !paused;
  assign cnt_clr   = bus.abort || bad_stage || (state == S_IDLE);

  stage_down_counter #(.TIMER_W(TIMER_W)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (load_val),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .zero     (cnt_zero),
    .count    (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      stage        <= STG_IDLE;
      timer_done_q <= 1'b0;
      cycle_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      timer_done_q <= 1'b0;
      cycle_done_q <= 1'b0;
      // Abort and corrupted stage values both collapse straight to idle.
      if (bus.abort || bad_stage) begin
        state  <= S_IDLE;
        stage  <= STG_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            stage  <= STG_IDLE;
            busy_q <= 1'b0;
            if (bus.next) begin
              stage  <= STG_FIRST;
              state  <= S_LOAD;
              busy_q <= 1'b1;
            end
          end
          S_LOAD: begin
            state  <= S_COUNT;
            busy_q <= 1'b1;
          end
          S_COUNT, S_EXPIRED: begin
            // An advance request beats expiry on the same cycle.
            if (bus.next) begin
              if (stage == STG_LAST) begin
                stage        <= STG_IDLE;
                state        <= S_IDLE;
                busy_q       <= 1'b0;
                cycle_done_q <= 1'b1;
              end else begin
                stage  <= stage + STAGE_W'(1);
                state  <= S_LOAD;
                busy_q <= 1'b1;
              end
            end else if (state == S_COUNT && !paused && cnt_zero) begin
              timer_done_q <= 1'b1;
              state        <= S_EXPIRED;
              busy_q       <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            stage  <= STG_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.stage_bus  = stage;
  assign bus.timer_done = timer_done_q;
  assign bus.cycle_done = cycle_done_q;
  assign bus.busy       = busy_q;
  assign bus.count      = cnt;

endmodule
